// File: rtl/pistorm_bus_pkg.sv
// Shared types and constants for the Atari-side 68000 bus responder.
`timescale 1ns/1ps
package pistorm_bus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DECODE   = 3'd1,
        WAIT     = 3'd2,
        ACK      = 3'd3,
        VPA_WAIT = 3'd4,
        TERM     = 3'd5,
        BERR     = 3'd6
    } resp_state_e;

    localparam logic [2:0]  FC_IACK      = 3'b111;
    localparam int          FC_SUPER_BIT = 2;
    localparam logic [23:0] DEF_REG_BASE = 24'hFF8E00;
    localparam logic [23:0] DEF_VPA_BASE = 24'hFFFC00;
    localparam int          WIN_ENTRIES  = 8;

    // Both windows are 16 bytes, so only A[23:4] takes part in the match.
    function automatic logic window_hit(input logic [23:0] addr, input logic [23:0] base);
        return (addr[23:4] == base[23:4]);
    endfunction

    function automatic logic [15:0] merge_lanes(input logic [15:0] cur,
                                                input logic [15:0] wr,
                                                input logic        uds_n,
                                                input logic        lds_n);
        logic [15:0] res;
        res = cur;
        if (!uds_n) res[15:8] = wr[15:8];
        else        res[15:8] = cur[15:8];
        if (!lds_n) res[7:0]  = wr[7:0];
        else        res[7:0]  = cur[7:0];
        return res;
    endfunction

endpackage

// File: rtl/bus_edge_sync.sv
// N-flop synchroniser for one asynchronous bus signal, with single-clock
// rise/fall pulses derived from the synchronised level.
`timescale 1ns/1ps
module bus_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_r;
    logic              last_r;

    // Shift chain plus one extra flop holding the previous synchronised level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= '0;
            last_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], din};
            last_r <= sync_r[STAGES-1];
        end
    end

    assign dout = sync_r[STAGES-1];
    assign rise = sync_r[STAGES-1] & ~last_r;
    assign fall = ~sync_r[STAGES-1] & last_r;

endmodule

// File: rtl/m68k_bus_responder.sv
// 68000 bus target: DTACK word window, VPA/E byte window and unclaimed-cycle
// BERR watchdog, all oversampled on PI_CLK.
`timescale 1ns/1ps
module m68k_bus_responder
    import pistorm_bus_pkg::*;
#(
    parameter logic [23:0] REG_BASE    = DEF_REG_BASE,
    parameter logic [23:0] VPA_BASE    = DEF_VPA_BASE,
    parameter int          WAIT_STATES = 2,
    parameter int          TIMEOUT     = 64,
    parameter bit          BERR_EN     = 1'b1
) (
    input  logic        PI_CLK,
    input  logic        RESET_n,
    input  logic        M68K_CLK,
    input  logic        M68K_E,
    input  logic        M68K_AS_n,
    input  logic        M68K_UDS_n,
    input  logic        M68K_LDS_n,
    input  logic        M68K_RW,
    input  logic [2:0]  M68K_FC,
    input  logic [23:1] M68K_A,
    input  logic [15:0] M68K_D_IN,
    output logic [15:0] M68K_D_OUT,
    output logic        M68K_D_OE,
    output logic        M68K_DTACK_n,
    output logic        M68K_VPA_n,
    input  logic        M68K_VMA_n,
    output logic        M68K_BERR_n,
    input  logic        EXT_ACK_n
);

    localparam int              WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [7:0]      WS_LAST = 8'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    logic clk_s, clk_rise_s, clk_fall_s;
    logic e_s, e_rise_s, e_fall_s;
    logic as_s, as_rise_s, as_fall_s;
    logic uds_s, uds_rise_s, uds_fall_s;
    logic lds_s, lds_rise_s, lds_fall_s;
    logic vma_s, vma_rise_s, vma_fall_s;
    logic unused_s;

    bus_edge_sync #(.STAGES(3)) u_sync_clk (.clk(PI_CLK), .rst_n(RESET_n), .din(M68K_CLK),
        .dout(clk_s), .rise(clk_rise_s), .fall(clk_fall_s));
    bus_edge_sync #(.STAGES(2)) u_sync_e   (.clk(PI_CLK), .rst_n(RESET_n), .din(M68K_E),
        .dout(e_s), .rise(e_rise_s), .fall(e_fall_s));
    bus_edge_sync #(.STAGES(2)) u_sync_as  (.clk(PI_CLK), .rst_n(RESET_n), .din(M68K_AS_n),
        .dout(as_s), .rise(as_rise_s), .fall(as_fall_s));
    bus_edge_sync #(.STAGES(2)) u_sync_uds (.clk(PI_CLK), .rst_n(RESET_n), .din(M68K_UDS_n),
        .dout(uds_s), .rise(uds_rise_s), .fall(uds_fall_s));
    bus_edge_sync #(.STAGES(2)) u_sync_lds (.clk(PI_CLK), .rst_n(RESET_n), .din(M68K_LDS_n),
        .dout(lds_s), .rise(lds_rise_s), .fall(lds_fall_s));
    bus_edge_sync #(.STAGES(2)) u_sync_vma (.clk(PI_CLK), .rst_n(RESET_n), .din(M68K_VMA_n),
        .dout(vma_s), .rise(vma_rise_s), .fall(vma_fall_s));

    assign unused_s = ^{clk_s, clk_rise_s, e_s, e_rise_s, as_rise_s, uds_rise_s, uds_fall_s,
                        lds_rise_s, lds_fall_s, vma_rise_s, vma_fall_s};

    resp_state_e     state_r;
    logic [23:1]     addr_r;
    logic            rw_r;
    logic [2:0]      fc_r;
    logic [15:0]     din_r;
    logic [7:0]      ws_cnt_r;
    logic            wd_arm_r;
    logic            vma_seen_r;
    logic [WD_W-1:0] wd_cnt_r;
    logic [15:0]     regs_r  [WIN_ENTRIES];
    logic [7:0]      vregs_r [WIN_ENTRIES];
    logic            dtack_n_r, vpa_n_r, berr_n_r, d_oe_r;
    logic [15:0]     d_out_r;

    logic            reg_hit_s, vpa_hit_s, wd_tick_s, wd_terminal_s;
    logic [2:0]      idx_s;

    // Address decode of the captured cycle and watchdog tick qualification.
    always_comb begin
        reg_hit_s     = window_hit({addr_r, 1'b0}, REG_BASE);
        vpa_hit_s     = window_hit({addr_r, 1'b0}, VPA_BASE);
        idx_s         = addr_r[3:1];
        wd_tick_s     = BERR_EN && (state_r == TERM) && wd_arm_r && !as_s && EXT_ACK_n && clk_fall_s;
        wd_terminal_s = wd_tick_s && (wd_cnt_r == WD_LAST);
    end

    // Watchdog counter: any claim or AS release restarts the count from zero.
    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            wd_cnt_r <= '0;
        end else if (as_s || !EXT_ACK_n || (state_r != TERM) || !wd_arm_r) begin
            wd_cnt_r <= '0;
        end else if (wd_tick_s && (wd_cnt_r != WD_MAX)) begin
            wd_cnt_r <= wd_cnt_r + 1'b1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    // Responder FSM with registered bus outputs and both register windows.
    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_r    <= IDLE;
            addr_r     <= '0;
            rw_r       <= 1'b0;
            fc_r       <= 3'b000;
            din_r      <= 16'h0000;
            ws_cnt_r   <= 8'd0;
            wd_arm_r   <= 1'b0;
            vma_seen_r <= 1'b0;
            dtack_n_r  <= 1'b1;
            vpa_n_r    <= 1'b1;
            berr_n_r   <= 1'b1;
            d_oe_r     <= 1'b0;
            d_out_r    <= 16'h0000;
            for (int i = 0; i < WIN_ENTRIES; i++) begin
                regs_r[i]  <= 16'h0000;
                vregs_r[i] <= 8'h00;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (as_fall_s) begin
                        addr_r     <= M68K_A;
                        rw_r       <= M68K_RW;
                        fc_r       <= M68K_FC;
                        din_r      <= M68K_D_IN;
                        ws_cnt_r   <= 8'd0;
                        vma_seen_r <= 1'b0;
                        wd_arm_r   <= 1'b0;
                        state_r    <= DECODE;
                    end
                end
                DECODE: begin
                    if (fc_r == FC_IACK) begin
                        wd_arm_r <= 1'b0;
                        state_r  <= TERM;
                    end else if (reg_hit_s && !fc_r[FC_SUPER_BIT]) begin
                        berr_n_r <= 1'b0;
                        state_r  <= BERR;
                    end else if (reg_hit_s) begin
                        state_r  <= (WAIT_STATES == 0) ? ACK : WAIT;
                    end else if (vpa_hit_s) begin
                        vpa_n_r  <= 1'b0;
                        state_r  <= VPA_WAIT;
                    end else begin
                        wd_arm_r <= BERR_EN;
                        state_r  <= TERM;
                    end
                end
                WAIT: begin
                    if (as_s) begin
                        state_r <= IDLE;
                    end else if (clk_fall_s) begin
                        if (ws_cnt_r == WS_LAST) state_r  <= ACK;
                        else                     ws_cnt_r <= ws_cnt_r + 8'd1;
                    end
                end
                ACK: begin
                    dtack_n_r <= 1'b0;
                    if (rw_r) begin
                        d_out_r <= regs_r[idx_s];
                        d_oe_r  <= 1'b1;
                    end else begin
                        regs_r[idx_s] <= merge_lanes(regs_r[idx_s], din_r, uds_s, lds_s);
                    end
                    state_r <= TERM;
                end
                VPA_WAIT: begin
                    if (as_s) begin
                        vpa_n_r <= 1'b1;
                        d_oe_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        if (!vma_s) begin
                            vma_seen_r <= 1'b1;
                            if (rw_r) begin
                                d_out_r <= {vregs_r[idx_s], 8'hFF};
                                d_oe_r  <= 1'b1;
                            end
                        end
                        // The E edge only counts once VMA has been seen on an earlier clock.
                        if (vma_seen_r && e_fall_s) begin
                            if (!rw_r && !uds_s) vregs_r[idx_s] <= din_r[15:8];
                            state_r <= TERM;
                        end
                    end
                end
                TERM: begin
                    if (as_s) begin
                        dtack_n_r <= 1'b1;
                        vpa_n_r   <= 1'b1;
                        d_oe_r    <= 1'b0;
                        wd_arm_r  <= 1'b0;
                        state_r   <= IDLE;
                    end else if (wd_terminal_s) begin
                        berr_n_r  <= 1'b0;
                        wd_arm_r  <= 1'b0;
                        state_r   <= BERR;
                    end
                end
                BERR: begin
                    if (as_s) begin
                        berr_n_r <= 1'b1;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    dtack_n_r <= 1'b1;
                    vpa_n_r   <= 1'b1;
                    berr_n_r  <= 1'b1;
                    d_oe_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign M68K_DTACK_n = dtack_n_r;
    assign M68K_VPA_n   = vpa_n_r;
    assign M68K_BERR_n  = berr_n_r;
    assign M68K_D_OE    = d_oe_r;
    assign M68K_D_OUT   = d_out_r;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed self-checking bench for m68k_bus_responder.
`timescale 1ns/1ps
module tb_m68k_bus_responder;

    logic        pi_clk = 1'b0, reset_n = 1'b0, m68k_clk = 1'b0, m68k_e = 1'b0;
    logic        as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1, vma_n = 1'b1, ext_ack_n = 1'b1;
    logic [2:0]  fc = 3'b101;
    logic [23:1] addr = '0;
    logic [15:0] d_in = 16'h0000;
    logic [15:0] d_out;
    logic        d_oe, dtack_n, vpa_n, berr_n;
    int          total = 0, bad = 0, fall_cnt = 0, start_cnt = 0, e_div = 0, overlap = 0;

    m68k_bus_responder dut (
        .PI_CLK(pi_clk), .RESET_n(reset_n), .M68K_CLK(m68k_clk), .M68K_E(m68k_e),
        .M68K_AS_n(as_n), .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw),
        .M68K_FC(fc), .M68K_A(addr), .M68K_D_IN(d_in), .M68K_D_OUT(d_out),
        .M68K_D_OE(d_oe), .M68K_DTACK_n(dtack_n), .M68K_VPA_n(vpa_n),
        .M68K_VMA_n(vma_n), .M68K_BERR_n(berr_n), .EXT_ACK_n(ext_ack_n)
    );

    always #2.5  pi_clk   = ~pi_clk;
    always #62.5 m68k_clk = ~m68k_clk;

    // E is M68K_CLK / 10: six clocks low, four high.
    always @(negedge m68k_clk) begin
        fall_cnt = fall_cnt + 1;
        e_div    = (e_div == 9) ? 0 : e_div + 1;
        m68k_e   = (e_div >= 6);
    end

    always @(negedge pi_clk) begin
        if (dtack_n === 1'b0 && berr_n === 1'b0) overlap = overlap + 1;
    end

    task automatic bus_start(input logic [23:0] a, input logic r, input logic [2:0] f,
                             input logic [15:0] d, input logic u, input logic l);
        @(posedge m68k_clk);
        #5;
        addr = a[23:1]; rw = r; fc = f; d_in = d; uds_n = u; lds_n = l;
        as_n = 1'b0;
        start_cnt = fall_cnt;
    endtask

    task automatic bus_end;
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; vma_n = 1'b1; rw = 1'b1;
        repeat (3) @(negedge pi_clk);
    endtask

    task automatic wait_resp(input int limit, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge pi_clk);
            if (dtack_n === 1'b0 || berr_n === 1'b0 || vpa_n === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_access(input logic [23:0] a, input logic r, input logic [15:0] d,
                             input logic u, input logic l, output logic [15:0] rd,
                             output logic oe, output bit to, output int edges);
        bus_start(a, r, 3'b101, d, u, l);
        wait_resp(2000, to);
        rd = d_out; oe = d_oe; edges = fall_cnt - start_cnt;
        bus_end();
    endtask

    task automatic do_reset;
        @(negedge pi_clk);
        reset_n = 1'b0;
        repeat (3) @(negedge pi_clk);
        reset_n = 1'b1;
        repeat (4) @(negedge pi_clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge pi_clk);
        total++; if (dtack_n !== 1'b1) begin bad++; $display("FAIL reset_dtack: got %b want 1", dtack_n); end
        total++; if (vpa_n !== 1'b1) begin bad++; $display("FAIL reset_vpa: got %b want 1", vpa_n); end
        total++; if (berr_n !== 1'b1) begin bad++; $display("FAIL reset_berr: got %b want 1", berr_n); end
        total++; if (d_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", d_oe); end
        total++; if (d_out !== 16'h0000) begin bad++; $display("FAIL reset_dout: got %h want 0000", d_out); end
        reset_n = 1'b1;
        repeat (5) @(negedge pi_clk);
    endtask

    task automatic test_reg_write_read;
        logic [15:0] rd; logic oe; bit to; int edges;
        do_access(24'hFF8E06, 1'b0, 16'hA55A, 1'b0, 1'b0, rd, oe, to, edges);
        total++; if (to) begin bad++; $display("FAIL wr_ack: got timeout want DTACK"); end
        total++; if (edges != 2) begin bad++; $display("FAIL wr_dtack_edge: got %0d want 2", edges); end
        total++; if (dtack_n !== 1'b1) begin bad++; $display("FAIL wr_release: got %b want 1", dtack_n); end
        do_access(24'hFF8E06, 1'b1, 16'h0000, 1'b0, 1'b0, rd, oe, to, edges);
        total++; if (to || rd !== 16'hA55A) begin bad++; $display("FAIL rd_data: got %h to=%0d want a55a", rd, to); end
        total++; if (oe !== 1'b1) begin bad++; $display("FAIL rd_oe: got %b want 1", oe); end
        total++; if (edges != 2) begin bad++; $display("FAIL rd_dtack_edge: got %0d want 2", edges); end
        total++; if (d_oe !== 1'b0 || dtack_n !== 1'b1) begin bad++; $display("FAIL rd_release: got oe=%b dtack=%b want 0/1", d_oe, dtack_n); end
    endtask

    task automatic test_byte_lanes;
        logic [15:0] rd; logic oe; bit to; int edges;
        do_access(24'hFF8E00, 1'b0, 16'h1234, 1'b0, 1'b1, rd, oe, to, edges);
        do_access(24'hFF8E00, 1'b1, 16'h0000, 1'b0, 1'b0, rd, oe, to, edges);
        total++; if (to || rd !== 16'h1200) begin bad++; $display("FAIL uds_lane: got %h want 1200", rd); end
        do_access(24'hFF8E00, 1'b0, 16'hABCD, 1'b1, 1'b0, rd, oe, to, edges);
        do_access(24'hFF8E00, 1'b1, 16'h0000, 1'b0, 1'b0, rd, oe, to, edges);
        total++; if (to || rd !== 16'h12CD) begin bad++; $display("FAIL lds_lane: got %h want 12cd", rd); end
        do_access(24'hFF8E06, 1'b1, 16'h0000, 1'b0, 1'b0, rd, oe, to, edges);
        total++; if (to || rd !== 16'hA55A) begin bad++; $display("FAIL other_word: got %h want a55a", rd); end
    endtask

    task automatic test_user_mode;
        logic [15:0] rd; logic oe; bit to; int edges;
        for (int k = 0; k < 2; k++) begin
            bus_start(24'hFF8E00, k[0], 3'b001, 16'hFFFF, 1'b0, 1'b0);
            wait_resp(2000, to);
            repeat (20) @(negedge pi_clk);
            total++; if (to || berr_n !== 1'b0) begin bad++; $display("FAIL user_berr%0d: got %b want 0", k, berr_n); end
            total++; if (dtack_n !== 1'b1) begin bad++; $display("FAIL user_dtack%0d: got %b want 1", k, dtack_n); end
            bus_end();
            total++; if (berr_n !== 1'b1) begin bad++; $display("FAIL user_release%0d: got %b want 1", k, berr_n); end
        end
        do_access(24'hFF8E00, 1'b1, 16'h0000, 1'b0, 1'b0, rd, oe, to, edges);
        total++; if (to || rd !== 16'h12CD) begin bad++; $display("FAIL user_nowrite: got %h want 12cd", rd); end
    endtask

    task automatic test_vpa;
        bit to;
        do_reset();
        bus_start(24'hFFFC02, 1'b0, 3'b101, 16'h3C00, 1'b0, 1'b1);
        wait_resp(2000, to);
        total++; if (to || vpa_n !== 1'b0) begin bad++; $display("FAIL vpa_wr_assert: got %b want 0", vpa_n); end
        @(negedge m68k_e); #20; vma_n = 1'b0;
        @(negedge m68k_e);
        repeat (10) @(negedge pi_clk);
        total++; if (vpa_n !== 1'b0 || dtack_n !== 1'b1) begin bad++; $display("FAIL vpa_wr_hold: got vpa=%b dtack=%b want 0/1", vpa_n, dtack_n); end
        bus_end();
        total++; if (vpa_n !== 1'b1) begin bad++; $display("FAIL vpa_wr_release: got %b want 1", vpa_n); end
        bus_start(24'hFFFC02, 1'b1, 3'b101, 16'h0000, 1'b0, 1'b0);
        wait_resp(2000, to);
        total++; if (to || vpa_n !== 1'b0) begin bad++; $display("FAIL vpa_rd_assert: got %b want 0", vpa_n); end
        @(negedge m68k_e); #20; vma_n = 1'b0;
        repeat (10) @(negedge pi_clk);
        total++; if (d_oe !== 1'b1 || d_out !== 16'h3CFF) begin bad++; $display("FAIL vpa_rd_data: got oe=%b d=%h want 1/3cff", d_oe, d_out); end
        @(negedge m68k_e);
        repeat (10) @(negedge pi_clk);
        total++; if (vpa_n !== 1'b0 || dtack_n !== 1'b1) begin bad++; $display("FAIL vpa_rd_hold: got vpa=%b dtack=%b want 0/1", vpa_n, dtack_n); end
        bus_end();
        total++; if (vpa_n !== 1'b1 || d_oe !== 1'b0) begin bad++; $display("FAIL vpa_rd_release: got vpa=%b oe=%b want 1/0", vpa_n, d_oe); end
    endtask

    task automatic test_timeout;
        bit to; int edges;
        bus_start(24'h000000, 1'b1, 3'b101, 16'h0000, 1'b0, 1'b0);
        wait_resp(4000, to);
        edges = fall_cnt - start_cnt;
        total++; if (to || berr_n !== 1'b0) begin bad++; $display("FAIL timeout_berr: got %b want 0", berr_n); end
        total++; if (edges != 64) begin bad++; $display("FAIL timeout_edge: got %0d want 64", edges); end
        total++; if (dtack_n !== 1'b1) begin bad++; $display("FAIL timeout_dtack: got %b want 1", dtack_n); end
        bus_end();
        total++; if (berr_n !== 1'b1) begin bad++; $display("FAIL timeout_release: got %b want 1", berr_n); end
    endtask

    task automatic test_ext_ack;
        bit saw_berr; int edges;
        saw_berr = 1'b0;
        bus_start(24'h000000, 1'b1, 3'b101, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 2000 && (fall_cnt - start_cnt) < 10; i++) @(negedge pi_clk);
        ext_ack_n = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge pi_clk);
            if (berr_n !== 1'b1) saw_berr = 1'b1;
        end
        edges = fall_cnt - start_cnt;
        total++; if (saw_berr || edges < 70) begin bad++; $display("FAIL ext_ack_noberr: got berr_seen=%0d edges=%0d want 0/>=70", saw_berr, edges); end
        bus_end();
        ext_ack_n = 1'b1;
    endtask

    task automatic test_iack;
        bit saw;
        saw = 1'b0;
        bus_start(24'h000000, 1'b1, 3'b111, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) begin
            @(negedge pi_clk);
            if (berr_n !== 1'b1 || dtack_n !== 1'b1 || vpa_n !== 1'b1) saw = 1'b1;
        end
        total++; if (saw) begin bad++; $display("FAIL iack_silent: got response want none"); end
        bus_end();
    endtask

    task automatic test_reset_mid_ack;
        logic [15:0] rd; logic oe; bit to; int edges;
        do_access(24'hFF8E06, 1'b0, 16'hA55A, 1'b0, 1'b0, rd, oe, to, edges);
        bus_start(24'hFF8E06, 1'b1, 3'b101, 16'h0000, 1'b0, 1'b0);
        wait_resp(2000, to);
        total++; if (to || dtack_n !== 1'b0 || d_out !== 16'hA55A) begin bad++; $display("FAIL mid_ack_pre: got dtack=%b d=%h want 0/a55a", dtack_n, d_out); end
        #1.2;
        reset_n = 1'b0;
        #1;
        total++; if (dtack_n !== 1'b1 || d_oe !== 1'b0) begin bad++; $display("FAIL mid_ack_async: got dtack=%b oe=%b want 1/0", dtack_n, d_oe); end
        total++; if (d_out !== 16'h0000) begin bad++; $display("FAIL mid_ack_dout: got %h want 0000", d_out); end
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        repeat (4) @(negedge pi_clk);
        reset_n = 1'b1;
        repeat (4) @(negedge pi_clk);
        do_access(24'hFF8E06, 1'b1, 16'h0000, 1'b0, 1'b0, rd, oe, to, edges);
        total++; if (to || rd !== 16'h0000) begin bad++; $display("FAIL post_reset_read: got %h to=%0d want 0000", rd, to); end
    endtask

    initial begin
        test_reset();
        test_reg_write_read();
        test_byte_lanes();
        test_user_mode();
        test_vpa();
        test_timeout();
        test_ext_ack();
        test_iack();
        test_reset_mid_ack();
        total++; if (overlap != 0) begin bad++; $display("FAIL dtack_berr_overlap: got %0d clocks want 0", overlap); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
